// File: rtl/clkdiv_pkg.sv
// Shared constants, types and helpers for the clock divider bank.
// Divider state is held at a fixed internal width (CLKDIV_CNT_W); the
// external divisor port (DIV_W) is zero-extended into it, so DIV_W must
// not exceed CLKDIV_CNT_W.
package clkdiv_pkg;

    // Smallest divisor that still yields a low and a high phase.
    localparam int unsigned CLKDIV_MIN_DIV     = 2;
    // 27 MHz in, 500 kHz out.
    localparam int unsigned CLKDIV_DEFAULT_DIV = 54;
    // Internal counter/divisor width.
    localparam int unsigned CLKDIV_CNT_W       = 16;

    typedef logic [CLKDIV_CNT_W-1:0] clkdiv_cnt_t;

    // Per-channel divider state.
    typedef struct packed {
        clkdiv_cnt_t div;          // divisor in force for the current period
        clkdiv_cnt_t cnt;          // position in period, 0..div-1
        clkdiv_cnt_t pending_div;  // divisor waiting for the next wrap
        logic        pending;      // pending_div is valid
    } clkdiv_state_t;

    // Length of the low phase: floor(N/2). The high phase gets the rest.
    function automatic clkdiv_cnt_t clkdiv_lo_len(input clkdiv_cnt_t div);
        return div >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, divisor with deferred update,
// run/stop handling and lock indication. clk_o comes straight from a flop.
// Optional: CLKDIV_TICK_EN adds tick_o, high during the wrap cycle.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int RST_DIV = CLKDIV_DEFAULT_DIV
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        upd_i,
    input  clkdiv_cnt_t upd_div_i,
    output logic        pending_o,
    output logic        clk_o,
    output logic        locked_o
`ifdef CLKDIV_TICK_EN
    ,
    output logic        tick_o
`endif
);

    localparam clkdiv_cnt_t ONE = clkdiv_cnt_t'(1);

    clkdiv_state_t st_q, st_d;
    logic          run_q, run_d;
    logic          clk_q, clk_d;
    logic          locked_q, locked_d;
    logic          wrap;

    // Last cycle of the current period.
    assign wrap = run_q && (st_q.cnt == st_q.div - ONE);

    // Next-state: count, wrap/apply pending divisor, stop/start, lock.
    // An idle channel (run_q=0) sits at cnt=0; the first cycle enable is
    // seen high counts as cnt=0 of a fresh period, so leaving reset with
    // enable high gives a full-length first low phase.
    always_comb begin
        st_d     = st_q;
        run_d    = run_q;
        locked_d = locked_q;

        if (!run_q) begin
            if (enable_i) begin
                run_d    = 1'b1;
                st_d.cnt = ONE;
            end
        end else if (wrap) begin
            st_d.cnt = '0;
            if (st_q.pending) begin
                // New divisor takes over at a period boundary; lock only
                // after it has run one complete period.
                st_d.div     = st_q.pending_div;
                st_d.pending = 1'b0;
                locked_d     = 1'b0;
            end else begin
                locked_d = 1'b1;
            end
            if (!enable_i) begin
                run_d    = 1'b0;
                locked_d = 1'b0;
            end
        end else begin
            st_d.cnt = st_q.cnt + ONE;
        end

        if (upd_i) begin
            locked_d = 1'b0;
            if (!run_q && !enable_i) begin
                // Stopped channel: nothing to protect, apply at once.
                st_d.div = upd_div_i;
            end else begin
                st_d.pending     = 1'b1;
                st_d.pending_div = upd_div_i;
            end
        end

        clk_d = run_d && (st_d.cnt >= clkdiv_lo_len(st_d.div));
    end

    // State registers; reset drops any pending divisor.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            st_q.div         <= clkdiv_cnt_t'(RST_DIV);
            st_q.cnt         <= '0;
            st_q.pending_div <= '0;
            st_q.pending     <= 1'b0;
            run_q            <= 1'b0;
            clk_q            <= 1'b0;
            locked_q         <= 1'b0;
        end else begin
            st_q     <= st_d;
            run_q    <= run_d;
            clk_q    <= clk_d;
            locked_q <= locked_d;
        end
    end

    assign pending_o = st_q.pending;
    assign clk_o     = clk_q;
    assign locked_o  = locked_q;
`ifdef CLKDIV_TICK_EN
    assign tick_o    = wrap;
`endif

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent programmable clock dividers sharing one
// divisor-update port. Updates are deferred to the target channel's next
// period end; bad requests are swallowed and flagged on cfg_err.
// Optional: CLKDIV_TICK_EN adds the per-channel tick output.
module clock_divider_bank
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] locked
`ifdef CLKDIV_TICK_EN
    ,
    output logic [NUM_CH-1:0] tick
`endif
);

    logic [NUM_CH-1:0]      pend_w;
    logic [(1<<CH_W)-1:0]   pend_pad;
    logic                   ch_ok, div_ok, accept, good;
    logic                   cfg_err_q, cfg_err_d;
    clkdiv_cnt_t            upd_div;

    // Pad pending flags to the full cfg_ch range so an out-of-range
    // channel reads as not pending and its request is accepted (and flagged).
    always_comb begin
        pend_pad             = '0;
        pend_pad[NUM_CH-1:0] = pend_w;
    end

    assign cfg_ready = !pend_pad[cfg_ch];
    assign ch_ok     = 32'(cfg_ch) < NUM_CH;
    assign div_ok    = 32'(cfg_div) >= CLKDIV_MIN_DIV;
    assign accept    = cfg_valid && cfg_ready;
    assign good      = accept && ch_ok && div_ok;
    assign cfg_err_d = accept && !(ch_ok && div_ok);
    assign upd_div   = clkdiv_cnt_t'(cfg_div);

    // Rejected-update flag, one cycle after the accept.
    always_ff @(posedge clk_in) begin
        if (reset) cfg_err_q <= 1'b0;
        else       cfg_err_q <= cfg_err_d;
    end

    assign cfg_err = cfg_err_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clkdiv_channel #(
            .RST_DIV   (DEFAULT_DIV)
        ) u_ch (
            .clk_i     (clk_in),
            .reset_i   (reset),
            .enable_i  (enable[c]),
            .upd_i     (good && (cfg_ch == CH_W'(c))),
            .upd_div_i (upd_div),
            .pending_o (pend_w[c]),
            .clk_o     (clk_out[c]),
            .locked_o  (locked[c])
`ifdef CLKDIV_TICK_EN
            ,
            .tick_o    (tick[c])
`endif
        );
    end

endmodule

// File: doc/clock_divider_bank.md
CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of independent divider channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 8, meaning the divisor width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 54, meaning the reset divisor of every channel (27 MHz to 500 kHz).
REQ-004 SHALL use one clock and a synchronous, active-high reset, named as in the list below.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port enable, input, NUM_CH bits: per-channel run enable.
REQ-008 SHALL have port cfg_valid, input, 1 bit: the divisor-update request.
REQ-009 SHALL have port cfg_ready, output, 1 bit: the update can be accepted.
REQ-010 SHALL have port cfg_ch, input, $clog2(NUM_CH) bits (minimum 1): the target channel.
REQ-011 SHALL have port cfg_div, input, DIV_W bits: the new divisor N.
REQ-012 SHALL have port cfg_err, output, 1 bit: a one-cycle pulse on a rejected update.
REQ-013 SHALL have port clk_out, output, NUM_CH bits: the registered divided clocks.
REQ-014 SHALL have port locked, output, NUM_CH bits: the channel is running at its current divisor.
REQ-015 SHALL have port tick, output, NUM_CH bits, present only under CLKDIV_TICK_EN: a one-cycle pulse at each period end.

Function
REQ-016 SHALL give each channel a period of N clk_in cycles: clk_out low for floor(N/2) cycles, then high for ceil(N/2) cycles.
- N=54: 27 low / 27 high.
- N=5: 2 low / 3 high.
REQ-017 SHALL drive every clk_out bit directly from a flop, with no combinational path from input to clk_out.
REQ-018 SHALL give each channel a counter cnt running 0..N-1; the period end (wrap) is the cycle with cnt==N-1, and cnt returns to 0 on the next cycle.
REQ-019 SHALL accept an update when cfg_valid && cfg_ready; cfg_ready = !pending[cfg_ch] (combinational from cfg_ch).
REQ-020 SHALL store an accepted valid divisor as pending and apply it at the first wrap strictly after the accept cycle, so no period is ever truncated or stretched.
REQ-021 SHALL, if the accept coincides with a wrap, use the old N for one more full period.
REQ-022 SHALL treat cfg_div<2 or cfg_ch>=NUM_CH as invalid: the request is accepted, cfg_err pulses high on the next cycle, and no state changes.
REQ-023 SHALL, for each channel, clear locked on the cycle after an accept and set it on the wrap that ends the first complete period using the new N.
REQ-024 SHALL, after reset, set locked at the end of the first complete period.
REQ-025 SHALL, on enable falling, complete the current period, then hold cnt=0, clk_out=0 and locked=0.
REQ-026 SHALL, on enable rising, start a fresh period (low phase first) on the next cycle.
REQ-027 SHALL, if enable is low at accept, still apply the divisor immediately at the idle state; locked stays 0 until the channel runs a full period.
REQ-028 SHALL keep channels fully independent: an update to one channel never disturbs another's phase.

Reset
REQ-029 SHALL, on reset, set every channel to div=DEFAULT_DIV, cnt=0, clk_out=0, locked=0, pending=0.
REQ-030 SHALL, on reset, drive cfg_err=0 and tick=0.
REQ-031 SHALL give reset priority over all other inputs; an assertion mid-period or mid-update discards the pending divisor.

Configuration
REQ-032 SHALL use macro CLKDIV_TICK_EN for the tick feature.
- Defined: the tick port exists and pulses high for one cycle on each wrap while enabled.
- Undefined: the tick port and its logic are absent; all other behaviour is identical.

Structure
REQ-033 SHALL place the shared constants and types in package clkdiv_pkg:
- the minimum divisor constant (2);
- the default divisor;
- a per-channel state struct {div, cnt, pending_div, pending}.
REQ-034 SHALL instantiate sub-module clkdiv_channel NUM_CH times; it holds the counter, divisor, pending register, enable and locked logic.

Verification
REQ-035 SHALL cover reset release with enable=all ones and DEFAULT_DIV=54: clk_out low 27 cycles, then high 27 cycles; locked rises at cycle 54.
REQ-036 SHALL cover an update of ch1 to N=5 mid-period: the old period completes, then clk_out shows 2 low / 3 high; locked falls the cycle after the accept and rises after the first 5-cycle period; ch0 phase is unchanged.
REQ-037 SHALL cover cfg_div=1, and separately cfg_ch=NUM_CH: cfg_err pulses one cycle, the divisor is unchanged, and locked stays high.
REQ-038 SHALL cover a second update to ch1 while pending: cfg_ready=0 for ch1 and 1 for ch2; the ch2 update is accepted in the same cycle.
REQ-039 SHALL cover enable[0] dropped during the high phase: the high phase finishes, then clk_out=0 and locked=0; re-enable restarts with the low phase.
REQ-040 SHALL cover, with CLKDIV_TICK_EN and N=4, that tick pulses once every 4 cycles, coincident with cnt==3.
